// File: rtl/hall_call_dispatcher.sv
// hall_call_dispatcher: latches hall calls per floor and assigns each to the cheaper of two cars.
// Optional DISPATCH_ALT_TIE_EN: equal-cost assignments alternate between cars via a tie register.
module hall_call_dispatcher #(
    parameter int FLOORS       = 6,
    parameter int POS_W        = 4,
    parameter int AWAY_PENALTY = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLOORS-1:0] hall_call,
    input  logic [POS_W-1:0]  pos_left,
    input  logic [POS_W-1:0]  pos_right,
    input  logic              dir_left,
    input  logic              dir_right,
    input  logic              stopped_left,
    input  logic              stopped_right,
    output logic [FLOORS-1:0] req_left,
    output logic [FLOORS-1:0] req_right,
    output logic [FLOORS-1:0] pending
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        ASGN_L  = 2'd2,
        ASGN_R  = 2'd3
    } floor_state_t;

    localparam int                 SCAN_W    = 3;
    localparam int                 COST_W    = 5;
    localparam int                 SUM_W     = POS_W + 4;
    localparam logic [COST_W-1:0]  COST_MAX  = '1;
    localparam logic [POS_W-1:0]   POS_TOP   = POS_W'(2 * (FLOORS - 1));
    localparam logic [SCAN_W-1:0]  SCAN_LAST = SCAN_W'(FLOORS - 1);

    floor_state_t          state     [FLOORS];
    floor_state_t          state_nxt [FLOORS];
    logic [SCAN_W-1:0]     scan;
    logic [FLOORS-1:0]     served;
    logic [COST_W-1:0]     cost_l;
    logic [COST_W-1:0]     cost_r;
    logic                  pick_l;
    logic                  pick_r;
    logic                  tie;
`ifdef DISPATCH_ALT_TIE_EN
    logic                  tie_q;
    logic                  scan_fire;
`endif

    function automatic logic [COST_W-1:0] sat_cost(input logic [SUM_W-1:0] sum);
        if (sum > SUM_W'(COST_MAX))
            return COST_MAX;
        return sum[COST_W-1:0];
    endfunction

    // Distance in half-floors plus a penalty when the car heads away from the call.
    function automatic logic [COST_W-1:0] car_cost(input logic [POS_W-1:0]  pos,
                                                   input logic              dir,
                                                   input logic [SCAN_W-1:0] floor_idx);
        logic signed [POS_W+1:0] diff;
        logic [SUM_W-1:0]        mag;
        logic [SUM_W-1:0]        pen;
        logic                    away;
        diff = $signed({2'b00, pos}) - $signed({{(POS_W + 1 - SCAN_W){1'b0}}, floor_idx, 1'b0});
        if (diff < 0)
            mag = SUM_W'(-diff);
        else
            mag = SUM_W'(diff);
        away = dir ? (diff > 0) : (diff < 0);
        pen  = away ? SUM_W'(AWAY_PENALTY) : '0;
        if (pos > POS_TOP)
            return COST_MAX;
        return sat_cost(mag + pen);
    endfunction

    always_comb begin
        cost_l = car_cost(pos_left, dir_left, scan);
        cost_r = car_cost(pos_right, dir_right, scan);
        pick_l = 1'b0;
        pick_r = 1'b0;
        tie    = 1'b0;
        if (!(cost_l == COST_MAX && cost_r == COST_MAX)) begin
            if (cost_l < cost_r)
                pick_l = 1'b1;
            else if (cost_r < cost_l)
                pick_r = 1'b1;
            else
                tie = 1'b1;
        end
`ifdef DISPATCH_ALT_TIE_EN
        pick_r = pick_r | (tie & tie_q);
        pick_l = pick_l | (tie & ~tie_q);
`else
        pick_l = pick_l | tie;
`endif
    end

    always_comb begin
        served = '0;
`ifdef DISPATCH_ALT_TIE_EN
        scan_fire = 1'b0;
`endif
        for (int f = 0; f < FLOORS; f++) begin
            served[f] = (stopped_left  && pos_left  == POS_W'(2 * f)) ||
                        (stopped_right && pos_right == POS_W'(2 * f));
            state_nxt[f] = state[f];
            if (served[f]) begin
                state_nxt[f] = IDLE;
            end else if (hall_call[f] && state[f] == IDLE) begin
                state_nxt[f] = PENDING;
            end else if (scan == SCAN_W'(f) && state[f] == PENDING) begin
`ifdef DISPATCH_ALT_TIE_EN
                scan_fire = 1'b1;
`endif
                if (pick_l)
                    state_nxt[f] = ASGN_L;
                else if (pick_r)
                    state_nxt[f] = ASGN_R;
            end
        end
    end

    // State, scan pointer and decoded outputs all update on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan      <= '0;
            req_left  <= '0;
            req_right <= '0;
            pending   <= '0;
            for (int f = 0; f < FLOORS; f++)
                state[f] <= IDLE;
`ifdef DISPATCH_ALT_TIE_EN
            tie_q <= 1'b0;
`endif
        end else begin
            scan <= (scan == SCAN_LAST) ? '0 : scan + 1'b1;
            for (int f = 0; f < FLOORS; f++) begin
                state[f]     <= state_nxt[f];
                req_left[f]  <= (state_nxt[f] == ASGN_L);
                req_right[f] <= (state_nxt[f] == ASGN_R);
                pending[f]   <= (state_nxt[f] == PENDING);
            end
`ifdef DISPATCH_ALT_TIE_EN
            if (tie && scan_fire)
                tie_q <= ~tie_q;
`endif
        end
    end

endmodule

// File: doc/hall_call_dispatcher.md
# hall_call_dispatcher

Assigns hall-call buttons (one per floor, six floors) to the left or right elevator car and drives each car's request bitmap into the direction scoring system's `FloorsRequested` input. It sits between the hall button panel and the two car sequencers. It latches each press and scores both cars on distance and travel direction. It holds each assignment until a car stops at that floor.

## Interface
Parameters:
- `FLOORS`, 6: number of served floors; positions are half-floor encoded.
- `POS_W`, 4: position width. Position = 2*floor for a whole floor; odd values mean the car is between floors.
- `AWAY_PENALTY`, 12: cost added when a car is moving away from the call.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `hall_call` in FLOORS: button level or pulse, one bit per floor, sampled every cycle.
- `pos_left`, `pos_right` in POS_W: car half-floor positions.
- `dir_left`, `dir_right` in 1: car direction, 1 = up.
- `stopped_left`, `stopped_right` in 1: car is halted with doors open at its current position.
- `req_left`, `req_right` out FLOORS: registered per-floor assignment bitmaps. Concatenate as {req_left, req_right} into `FloorsRequested`.
- `pending` out FLOORS: calls latched but not yet assigned.

## Operation
- Per-floor 2-bit state, encoded IDLE=0, PENDING=1, ASGN_L=2, ASGN_R=3.
- Outputs decode from the registered state:
  - `req_left[f]` = (state==ASGN_L)
  - `req_right[f]` = (state==ASGN_R)
  - `pending[f]` = (state==PENDING)
- Scan pointer `scan` (3 bits) counts 0..FLOORS-1, advances every cycle, and wraps FLOORS-1→0. It is not gated by activity.
- A car X serves floor f when `stopped_X` is 1, `pos_X` == 2f, and `pos_X[0]` == 0.
- Per-floor next-state priority, highest first:
  1. Served by either car → IDLE. This applies from any state, including a press arriving in the same cycle.
  2. `hall_call[f]`=1 and state==IDLE → PENDING. A press in PENDING, ASGN_L or ASGN_R causes no change.
  3. `scan`==f and state==PENDING → assign the floor as described below.
- Cost for car X at floor f, 5-bit saturating at 31:
  - Base cost = |pos_X − 2f|.
  - Add AWAY_PENALTY if the car is moving away: `dir_X`=1 and pos_X > 2f, or `dir_X`=0 and pos_X < 2f.
  - `pos_X` > 2*(FLOORS−1) is invalid and costs 31.
- Assignment:
  - cost_L < cost_R → ASGN_L.
  - cost_R < cost_L → ASGN_R.
  - Equal costs → tie-break (see Configuration).
  - Both costs 31 → the floor stays PENDING.
- An assignment is never moved to the other car. It clears only by service or reset.

## Timing
- Reset values:
  - every floor state = IDLE
  - `req_left` = `req_right` = `pending` = 0
  - `scan` = 0
  - tie register = 0 (left)
- Press sampled at edge N → `pending[f]` = 1 after edge N.
- Assignment happens at the first edge where `scan`==f. Press-to-`req_*` latency is 1..FLOORS cycles, worst case 6.
- Service clear: `stopped_X` high at edge N → `req_X[f]` = 0 after edge N. Service of a PENDING floor clears `pending[f]` the same way.
- Reset asserted mid-operation clears all state immediately, with no partial assignment retained.
- Costs use the inputs sampled at the assigning edge. No input registering.

## Configuration
- `DISPATCH_ALT_TIE_EN` defined:
  - Equal costs go to the car named by a 1-bit tie register (0=left, 1=right).
  - The register toggles after each tie-broken assignment, giving alternating fairness.
- Not defined:
  - Ties always assign to the left car.
  - No tie register is instantiated.

## Test plan
- Reset, then no stimulus for 12 cycles → all outputs remain 0; `scan` cycles 0..5 twice.
- `pos_left`=0, `dir_left`=1; `pos_right`=10, `dir_right`=0; press floor 1 → `pending[1]`=1 next cycle; within 6 cycles `req_left[1]`=1 (cost 2 vs 8), `pending[1]`=0.
- `pos_left`=8, `dir_left`=1; `pos_right`=2, `dir_right`=1; press floor 2 → `req_right[2]`=1 (cost 2 vs 4+12=16).
- Both cars at `pos`=4, `dir`=1; press floors 0 then 1:
  - with `DISPATCH_ALT_TIE_EN`: floor 0 → left, floor 1 → right
  - without the macro: both → left
- Floor 3 in ASGN_L:
  - `pos_right`=6 with `stopped_right`=1 → `req_left[3]`=0 next cycle.
  - Hold the press during that stop → state stays IDLE.
- Press floor 4 and assert `rst` 2 cycles later → all outputs 0. After release, floor 4 is never assigned without a new press.
